// File: rtl/axi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi_pkg
// Brief    : Shared AXI B-channel types and response encoding helper.
// Revision : 1.0 - initial release
// ============================================================================
package axi_pkg;

  localparam int AXI_ID_W = 4;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0] id;
    resp_t               resp;
    logic                user;
  } b_beat_t;

  // Decode error outranks slave error; EXOKAY is never produced by a slave write path.
  function automatic resp_t encode_resp(input logic slverr, input logic decerr);
    resp_t r;
    if (decerr)      r = DECERR;
    else if (slverr) r = SLVERR;
    else             r = OKAY;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo_fwft.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_fwft
// Brief    : Single-clock first-word-fall-through FIFO; head is read from registered storage.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo_fwft #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int           AW       = $clog2(DEPTH);
  localparam logic [AW:0]  FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q,  count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // A full FIFO refuses a push even when a pop frees a slot in the same cycle.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i  & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule
`default_nettype wire

// File: rtl/axi_wr_rsp_gen.sv
`default_nettype none
// ============================================================================
// Module   : axi_wr_rsp_gen
// Brief    : AXI slave write-response generator: completion queue, B channel,
//            outstanding-burst gating, protocol error flag and response stats.
// Revision : 1.0 - initial release
// ============================================================================
module axi_wr_rsp_gen
  import axi_pkg::*;
#(
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 8,
  parameter int CNT_W           = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cpl_valid,
  output logic                cpl_ready,
  input  logic [AXI_ID_W-1:0] cpl_id,
  input  logic                cpl_slverr,
  input  logic                cpl_decerr,
  input  logic                cpl_user,
  input  logic                aw_accept,
  output logic                aw_allow,
  output logic                bvalid,
  input  logic                bready,
  output logic [AXI_ID_W-1:0] bid,
  output logic [1:0]          bresp,
  output logic                buser,
  output logic [7:0]          outstanding,
  output logic [CNT_W-1:0]    cnt_okay,
  output logic [CNT_W-1:0]    cnt_slverr,
  output logic [CNT_W-1:0]    cnt_decerr,
  input  logic                err_clr,
  output logic                proto_err
);

  localparam int         BEAT_W  = $bits(b_beat_t);
  localparam logic [7:0] MAX_OUT = 8'(MAX_OUTSTANDING);

  b_beat_t           push_beat;
  b_beat_t           head_beat;
  logic [BEAT_W-1:0] head_raw;
  logic              fifo_full, fifo_empty;
  logic              b_hs;
  logic              viol;

  logic [7:0]        outstanding_q, outstanding_d;
  logic              proto_err_q,   proto_err_d;
  logic [CNT_W-1:0]  cnt_okay_q,    cnt_okay_d;
  logic [CNT_W-1:0]  cnt_slverr_q,  cnt_slverr_d;
  logic [CNT_W-1:0]  cnt_decerr_q,  cnt_decerr_d;

  assign push_beat = {cpl_id, encode_resp(cpl_slverr, cpl_decerr), cpl_user};
  assign head_beat = b_beat_t'(head_raw);

  sync_fifo_fwft #(
    .WIDTH (BEAT_W),
    .DEPTH (DEPTH)
  ) u_cpl_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (cpl_valid),
    .wdata_i (push_beat),
    .pop_i   (b_hs),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (head_raw)
  );

  // Payload is forced to zero while idle so the bus never shows stale storage.
  assign cpl_ready = ~fifo_full;
  assign bvalid    = ~fifo_empty;
  assign bid       = bvalid ? head_beat.id   : '0;
  assign bresp     = bvalid ? head_beat.resp : 2'b00;
  assign buser     = bvalid ? head_beat.user : 1'b0;
  assign b_hs      = bvalid & bready;

  assign aw_allow    = (outstanding_q < MAX_OUT);
  assign outstanding = outstanding_q;
  assign proto_err   = proto_err_q;
  assign cnt_okay    = cnt_okay_q;
  assign cnt_slverr  = cnt_slverr_q;
  assign cnt_decerr  = cnt_decerr_q;

  always_comb begin
    outstanding_d = outstanding_q;
    viol          = 1'b0;
    case ({aw_accept, b_hs})
      2'b10: begin
        if (outstanding_q == MAX_OUT) viol = 1'b1;
        else                          outstanding_d = outstanding_q + 8'd1;
      end
      2'b01: begin
        if (outstanding_q == 8'd0) viol = 1'b1;
        else                       outstanding_d = outstanding_q - 8'd1;
      end
      default: outstanding_d = outstanding_q;
    endcase
    // A violation in the clearing cycle keeps the flag set.
    proto_err_d = viol | (proto_err_q & ~err_clr);
  end

  always_comb begin
    cnt_okay_d   = cnt_okay_q;
    cnt_slverr_d = cnt_slverr_q;
    cnt_decerr_d = cnt_decerr_q;
    if (b_hs) begin
      case (head_beat.resp)
        OKAY:    if (cnt_okay_q   != '1) cnt_okay_d   = cnt_okay_q   + CNT_W'(1);
        SLVERR:  if (cnt_slverr_q != '1) cnt_slverr_d = cnt_slverr_q + CNT_W'(1);
        DECERR:  if (cnt_decerr_q != '1) cnt_decerr_d = cnt_decerr_q + CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding_q <= '0;
      proto_err_q   <= 1'b0;
      cnt_okay_q    <= '0;
      cnt_slverr_q  <= '0;
      cnt_decerr_q  <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      proto_err_q   <= proto_err_d;
      cnt_okay_q    <= cnt_okay_d;
      cnt_slverr_q  <= cnt_slverr_d;
      cnt_decerr_q  <= cnt_decerr_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_wr_rsp_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_wr_rsp_gen
// Brief    : Directed and randomized bench for axi_wr_rsp_gen with a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_wr_rsp_gen;

  localparam int DEPTH = 4;
  localparam int MAXO  = 8;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk, rst_n;
  logic          cpl_valid, cpl_ready, cpl_slverr, cpl_decerr, cpl_user;
  logic [3:0]    cpl_id;
  logic          aw_accept, aw_allow;
  logic          bvalid, bready, buser;
  logic [3:0]    bid;
  logic [1:0]    bresp;
  logic [7:0]    outstanding;
  logic [CW-1:0] cnt_okay, cnt_slverr, cnt_decerr;
  logic          err_clr, proto_err;

  axi_wr_rsp_gen #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpl_valid(cpl_valid), .cpl_ready(cpl_ready), .cpl_id(cpl_id),
    .cpl_slverr(cpl_slverr), .cpl_decerr(cpl_decerr), .cpl_user(cpl_user),
    .aw_accept(aw_accept), .aw_allow(aw_allow),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp), .buser(buser),
    .outstanding(outstanding),
    .cnt_okay(cnt_okay), .cnt_slverr(cnt_slverr), .cnt_decerr(cnt_decerr),
    .err_clr(err_clr), .proto_err(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] id;
    logic [1:0] resp;
    logic       user;
  } beat_s;

  beat_s mq[$];
  int    m_out;
  bit    m_perr;
  int    m_cnt[4];
  int    total = 0;
  int    bad   = 0;
  bit    chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_out  = 0;
    m_perr = 1'b0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
  endtask

  // Applies one clock of the specification's rules to the model state.
  task automatic model_step();
    beat_s b;
    bit    hs, push, viol;
    if (!rst_n) begin
      model_reset();
      return;
    end
    hs   = (mq.size() != 0) && bready;
    push = cpl_valid && (mq.size() < DEPTH);
    if (hs) begin
      b = mq.pop_front();
      if (m_cnt[b.resp] < CMAX) m_cnt[b.resp]++;
    end
    if (push) begin
      b.id   = cpl_id;
      b.resp = cpl_decerr ? 2'b11 : (cpl_slverr ? 2'b10 : 2'b00);
      b.user = cpl_user;
      mq.push_back(b);
    end
    viol = 1'b0;
    if (aw_accept && !hs) begin
      if (m_out == MAXO) viol = 1'b1;
      else               m_out++;
    end else if (hs && !aw_accept) begin
      if (m_out == 0) viol = 1'b1;
      else            m_out--;
    end
    m_perr = viol || (m_perr && !err_clr);
  endtask

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      check("bvalid",      bvalid,      mq.size() != 0);
      check("bid",         bid,         (mq.size() != 0) ? mq[0].id   : 4'h0);
      check("bresp",       bresp,       (mq.size() != 0) ? mq[0].resp : 2'b00);
      check("buser",       buser,       (mq.size() != 0) ? mq[0].user : 1'b0);
      check("cpl_ready",   cpl_ready,   mq.size() < DEPTH);
      check("outstanding", outstanding, m_out);
      check("aw_allow",    aw_allow,    m_out < MAXO);
      check("proto_err",   proto_err,   m_perr);
      check("cnt_okay",    cnt_okay,    m_cnt[0]);
      check("cnt_slverr",  cnt_slverr,  m_cnt[2]);
      check("cnt_decerr",  cnt_decerr,  m_cnt[3]);
    end
  end

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic cv, input logic [3:0] id, input logic se, input logic de,
                       input logic us, input logic awa, input logic br, input logic clr);
    cpl_valid  = cv;
    cpl_id     = id;
    cpl_slverr = se;
    cpl_decerr = de;
    cpl_user   = us;
    aw_accept  = awa;
    bready     = br;
    err_clr    = clr;
    cycle();
  endtask

  initial begin
    rst_n = 1'b0;
    cpl_valid = 0; cpl_id = 0; cpl_slverr = 0; cpl_decerr = 0; cpl_user = 0;
    aw_accept = 0; bready = 0; err_clr = 0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    rst_n  = 1'b1;
    chk_en = 1'b1;

    check("rst_bvalid",    bvalid,      0);
    check("rst_cpl_ready", cpl_ready,   1);
    check("rst_aw_allow",  aw_allow,    1);
    check("rst_out",       outstanding, 0);
    check("rst_perr",      proto_err,   0);

    // Single OKAY response, one-cycle latency.
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    drive(1, 4'h5, 0, 0, 0, 0, 1, 0);
    check("t1_bvalid", bvalid, 1);
    check("t1_bid",    bid,    5);
    check("t1_bresp",  bresp,  0);
    check("t1_out1",   outstanding, 1);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    check("t1_out0",   outstanding, 0);
    check("t1_okay",   cnt_okay,    1);

    // Fill, stall with stable payload, then back-to-back drain.
    for (int i = 1; i <= 4; i++) drive(1, 4'(i), 0, 0, 0, 1, 0, 0);
    check("t2_full", cpl_ready, 0);
    for (int i = 0; i < 2; i++) begin
      drive(1, 4'h5, 0, 0, 0, 0, 0, 0);
      check("t2_stall_bid", bid,       1);
      check("t2_stall_rdy", cpl_ready, 0);
    end
    for (int i = 1; i <= 4; i++) begin
      check("t2_drain_bid", bid, i);
      drive(0, 0, 0, 0, 0, 0, 1, 0);
    end
    check("t2_empty", bvalid,      0);
    check("t2_out",   outstanding, 0);
    check("t2_okay",  cnt_okay,    5);

    // Response encoding priority.
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    drive(1, 4'h6, 1, 1, 0, 0, 0, 0);
    check("t3_decerr", bresp, 2'b11);
    drive(1, 4'h7, 1, 0, 1, 0, 1, 0);
    check("t3_slverr", bresp, 2'b10);
    check("t3_buser",  buser, 1);
    check("t3_cdec",   cnt_decerr, 1);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    check("t3_cslv",   cnt_slverr, 1);
    check("t3_out",    outstanding, 0);

    // Outstanding limit and overflow violation.
    repeat (8) drive(0, 0, 0, 0, 0, 1, 0, 0);
    check("t4_out8",  outstanding, 8);
    check("t4_allow", aw_allow,    0);
    check("t4_perr0", proto_err,   0);
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    check("t4_perr1", proto_err,   1);
    check("t4_hold",  outstanding, 8);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    check("t4_clr",   proto_err,   0);

    // Drain to 3, coincident AW + B, then underflow and saturation.
    for (int i = 0; i < 5; i++) drive(1, 4'(i), 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    check("t5_out3a", outstanding, 3);
    drive(1, 4'h9, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 1, 0);
    check("t5_out3b", outstanding, 3);
    check("t5_perr0", proto_err,   0);
    for (int i = 0; i < 4; i++) drive(1, 4'(i), 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0, 0, 1, 0);
    check("t5_out0",  outstanding, 0);
    check("t5_perr1", proto_err,   1);
    check("t5_okay",  cnt_okay,    15);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    check("t5_clr",   proto_err,   0);
    drive(1, 4'hA, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 1);
    check("t5_clr_vs_viol", proto_err, 1);
    check("t5_okay_sat",    cnt_okay,  15);
    drive(0, 0, 0, 0, 0, 0, 0, 1);

    // Asynchronous reset with queued responses.
    for (int i = 0; i < 3; i++) drive(1, 4'(i + 1), 0, 0, 0, 1, 0, 0);
    check("t6_bvalid_pre", bvalid, 1);
    rst_n = 1'b0;
    #1;
    check("t6_async_bvalid", bvalid,      0);
    check("t6_async_ready",  cpl_ready,   1);
    check("t6_async_out",    outstanding, 0);
    model_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    check("t6_bvalid", bvalid,     0);
    check("t6_okay",   cnt_okay,   0);
    check("t6_slv",    cnt_slverr, 0);
    check("t6_dec",    cnt_decerr, 0);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      drive(1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 4) == 0), 1'($urandom), 1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 19) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
